// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: round-robin ALU/MEM arbitration into a
// registered write port, plus a per-register pending-write scoreboard for decode.
module rf_writeback_ctrl #(
  parameter int WORD_W   = 16,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [1:0]        issue_dest,
  output logic              issue_ready,
  input  logic              alu_valid,
  input  logic [1:0]        alu_dest,
  input  logic [WORD_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [1:0]        mem_dest,
  input  logic [WORD_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic [1:0]        chk_addr_a,
  input  logic [1:0]        chk_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              rf_write,
  output logic [1:0]        rf_waddr,
  output logic [WORD_W-1:0] rf_wdata,
  output logic [3:0]        busy,
  output logic              wb_err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_PEND);

  logic [1:0] cnt     [4];
  logic [1:0] cnt_nxt [4];
  logic       prio_mem;
  logic       issue_acc;
  logic       retire_err;

  // Ties go to the source that did not win last; prio_mem=1 means mem wins a tie.
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (mem_valid && alu_valid) begin
      mem_ready = prio_mem;
      alu_ready = !prio_mem;
    end else begin
      mem_ready = mem_valid;
      alu_ready = alu_valid;
    end
  end

  assign issue_ready = (cnt[issue_dest] != MAX_CNT);
  assign issue_acc   = issue_valid && issue_ready;
  assign hazard_a    = (cnt[chk_addr_a] != 2'd0);
  assign hazard_b    = (cnt[chk_addr_b] != 2'd0);
  assign retire_err  = rf_write && (cnt[rf_waddr] == 2'd0);

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      busy[r]    = (cnt[r] != 2'd0);
      cnt_nxt[r] = cnt[r];
      if (issue_acc && (issue_dest == 2'(r)) && !(rf_write && (rf_waddr == 2'(r))))
        cnt_nxt[r] = cnt[r] + 2'd1;
      else if (rf_write && (rf_waddr == 2'(r)) && !(issue_acc && (issue_dest == 2'(r)))
               && (cnt[r] != 2'd0))
        cnt_nxt[r] = cnt[r] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < 4; r++) cnt[r] <= 2'd0;
      prio_mem <= 1'b1;
      rf_write <= 1'b0;
      rf_waddr <= 2'd0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      for (int r = 0; r < 4; r++) cnt[r] <= cnt_nxt[r];
      if (retire_err) wb_err <= 1'b1;
      rf_write <= mem_ready || alu_ready;
      if (mem_ready) begin
        rf_waddr <= mem_dest;
        rf_wdata <= mem_data;
        prio_mem <= 1'b0;
      end else if (alu_ready) begin
        rf_waddr <= alu_dest;
        rf_wdata <= alu_data;
        prio_mem <= 1'b1;
      end
    end
  end

endmodule
